mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the multicycle CPU. Sits downstream of the instruction controller and consumes its MUL_C, DIV_C and S_mdu strobes plus the rs/rt operands. It computes 64-bit products and 32-bit quotient/remainder pairs over multiple cycles and presents HI/LO results with a busy/done handshake, so the controller can hold in T3 until the result is ready.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH each.
- ITER, 32, iterations per multiply or divide; must equal WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request strobe, sampled on the rising edge.
- mul_c  in  1  multiply request (MULT/MULTU/MUL).
- div_c  in  1  divide request (DIV/DIVU).
- s_mdu  in  1  1 = signed operands, 0 = unsigned.
- a  in  WIDTH  rs operand: multiplicand or dividend.
- b  in  WIDTH  rt operand: multiplier or divisor.
- hi  out  WIDTH  product[63:32] or remainder.
- lo  out  WIDTH  product[31:0] or quotient.
- busy  out  1  operation in flight; the controller stalls while high.
- done  out  1  one-cycle pulse; hi/lo are valid from this cycle.
- dz  out  1  last divide had divisor 0; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- A request is accepted when start=1, mul_c^div_c=1, and the state is IDLE or DONE.
  - All other start cycles are ignored with no side effects. This includes starts while busy, and starts with both or neither of mul_c/div_c set.
- On accept:
  - Latch |a| and |b| (magnitudes if s_mdu=1, raw values otherwise).
  - Latch sign_a, sign_b and the operation type.
  - Clear the iteration counter and clear dz.
- Multiply uses radix-2 shift-add on the magnitudes.
  - Each CALC cycle handles one multiplier bit, LSB first, into a 64-bit accumulator.
- Divide uses restoring division on the magnitudes.
  - Each CALC cycle shifts the {rem, quo} pair left by one, trial-subtracts the divisor, and sets the quotient bit if the result is non-negative.
- CALC → FIX when counter == ITER-1.
- FIX applies signs and registers the result:
  - Signed multiply: 64-bit result negated if sign_a^sign_b.
  - Signed divide: quotient negated if sign_a^sign_b; remainder negated if sign_a. The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0. This is the natural wrap; no trap is raised.
- Divide by zero (b==0 at accept):
  - Skip CALC; go IDLE → FIX directly.
  - Result: lo=0xFFFFFFFF, hi=a (raw), dz=1.
- FIX → DONE. DONE → IDLE, unless a new request is accepted in DONE, which goes DONE → CALC.
- hi/lo change only in FIX and hold otherwise. MTHI/MTLO writes are outside this block.

## Timing
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, dz=0; counter=0. Reset takes effect immediately, including mid-operation, and the in-flight result is discarded.
- Edge numbering: E0 is the accepting edge.
- Iterative path: E1..E32 are CALC iterations, E33 is FIX, and done=1 in the cycle after E33. Latency is 34 cycles from the start cycle to the done cycle.
- Short path (divide by zero, and fast multiply with the macro below): E1 is FIX, and done=1 in the cycle after E1.
- busy=1 in CALC and FIX, 0 in IDLE and DONE.
- done=1 only in DONE, for exactly one cycle.
- An accept in DONE gives busy=1 from the following cycle; done still pulses in the DONE cycle.
- Operand inputs are don't-care after E0.

## Configuration
- MDU_FAST_MUL_EN defined:
  - Multiply goes IDLE → FIX and forms the 64-bit product with one combinational multiplier at E1.
  - Multiply latency is 2 cycles; divide is unchanged.
- MDU_FAST_MUL_EN undefined: multiply uses the 32-iteration shift-add path.
- Results are bit-identical in both builds.

## Structure
- Package mdu_pkg holds:
  - the state encoding (IDLE/CALC/FIX/DONE);
  - the ITER default;
  - the divide-by-zero constants (DZ_LO=32'hFFFFFFFF).
- One sub-module, mdu_divstep: a combinational single restoring step. It takes {rem, quo} and the divisor and returns the next {rem, quo}. It is instantiated once inside the CALC datapath.
- The sign fix-up stays inline in the FIX logic.

## Test plan
- Unsigned multiply, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start (2 cycles with MDU_FAST_MUL_EN).
- Signed multiply, a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- Signed divide, a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed divide, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000, dz=0.
- Divide, a=0x00001234, b=0 → lo=0xFFFFFFFF, hi=0x00001234, dz=1; done 2 cycles after start.
- Start a divide, pulse start again at iteration 5 (ignored), assert reset at iteration 10 → immediately hi=lo=0, busy=done=dz=0. After release, a new unsigned divide 100/7 → lo=14, hi=2.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int unsigned ITER_DEF = 32;

  // Divide-by-zero result: quotient is all ones, remainder is the raw dividend.
  localparam logic [31:0] DZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step on a {rem, quo} pair.
module mdu_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   trial;

  // Shift {rem, quo} left, trial-subtract, keep the difference if it did not borrow.
  // The bit shifted out of rem is kept as trial's MSB so the compare stays exact.
  always_comb begin
    rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    trial     = {rem[WIDTH-1], rem_shift} - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift;
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with busy/done handshake and HI/LO results.
// Optional build macro: MDU_FAST_MUL_EN (single-cycle combinational multiply).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = ITER_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mul_c,
  input  logic             div_c,
  input  logic             s_mdu,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CW = $clog2(ITER);

  state_t           state, state_next;
  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [CW-1:0]    cnt;
  logic             op_mul, sgn, sign_a, sign_b, dz_pend;
  logic [WIDTH-1:0] work_hi, work_lo, opnd;

  logic [WIDTH-1:0] div_rem, div_quo;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Operand magnitudes and request qualification.
  always_comb begin
    a_mag  = (s_mdu && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag  = (s_mdu && b[WIDTH-1]) ? (~b + 1'b1) : b;
    b_zero = (b == '0);
    accept = start && (mul_c ^ div_c) && ((state == S_IDLE) || (state == S_DONE));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done       = (state == S_DONE);
        state_next = S_IDLE;
        if (accept) begin
          if (div_c && b_zero) state_next = S_FIX;
`ifdef MDU_FAST_MUL_EN
          else if (mul_c)      state_next = S_FIX;
`endif
          else                 state_next = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == CW'(ITER - 1)) state_next = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (work_hi),
    .quo      (work_lo),
    .divisor  (opnd),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the 65-bit {carry, hi, lo} accumulator right by one.
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
  end

  // Sign fix-up of the magnitude result.
  always_comb begin
`ifdef MDU_FAST_MUL_EN
    prod = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, work_lo};
`else
    prod = {work_hi, work_lo};
`endif
    res_hi = work_hi;
    res_lo = work_lo;
    if (dz_pend) begin
      res_hi = work_hi;
      res_lo = DZ_LO;
    end else if (op_mul) begin
      if (sgn && (sign_a ^ sign_b)) prod = ~prod + 1'b1;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      res_lo = (sgn && (sign_a ^ sign_b)) ? (~work_lo + 1'b1) : work_lo;
      res_hi = (sgn && sign_a)            ? (~work_hi + 1'b1) : work_hi;
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, register results in FIX.
  // For multiply work_lo holds the multiplier and opnd the multiplicand; for
  // divide work_lo holds the dividend/quotient and opnd the divisor. A
  // divide by zero preloads work_hi with the raw dividend to become HI.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      op_mul  <= 1'b0;
      sgn     <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dz_pend <= 1'b0;
      work_hi <= '0;
      work_lo <= '0;
      opnd    <= '0;
      hi      <= '0;
      lo      <= '0;
      dz      <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      op_mul  <= mul_c;
      sgn     <= s_mdu;
      sign_a  <= s_mdu & a[WIDTH-1];
      sign_b  <= s_mdu & b[WIDTH-1];
      dz      <= 1'b0;
      if (mul_c) begin
        dz_pend <= 1'b0;
        work_hi <= '0;
        work_lo <= b_mag;
        opnd    <= a_mag;
      end else begin
        dz_pend <= b_zero;
        work_hi <= b_zero ? a : '0;
        work_lo <= a_mag;
        opnd    <= b_mag;
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + 1'b1;
      if (op_mul) begin
        work_hi <= mul_sum[WIDTH:1];
        work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
      end else begin
        work_hi <= div_rem;
        work_lo <= div_quo;
      end
    end else if (state == S_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
      dz <= dz_pend;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mul_c, div_c, s_mdu;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, dz;

  int tests = 0;
  int fails = 0;
  int lat, bcnt;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT  = 2;
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_LAT  = 34;
  localparam int MUL_BUSY = 33;
`endif

  mdu_iter #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mul_c (mul_c),
    .div_c (div_c),
    .s_mdu (s_mdu),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; lat counts cycles from the
  // start cycle to the done cycle, bc counts busy cycles in between.
  task automatic run_op(input logic m, input logic d, input logic s,
                        input logic [31:0] av, input logic [31:0] bv,
                        output int lt, output int bc);
    @(negedge clk);
    start = 1'b1; mul_c = m; div_c = d; s_mdu = s; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    lt = 1; bc = 0;
    while (!done && lt < 100) begin
      if (busy) bc++;
      @(negedge clk);
      lt++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mul_c = 1'b0; div_c = 1'b0; s_mdu = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_dz", {31'b0, dz}, 32'h0);
    reset = 1'b1;

    // Unsigned multiply of max operands
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    chk("umul_hi", hi, 32'hFFFF_FFFE);
    chk("umul_lo", lo, 32'h0000_0001);
    chk("umul_lat", lat, MUL_LAT);
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'h0);

    // Signed multiply -3 * 7
    run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
    chk("smul_hi", hi, 32'hFFFF_FFFF);
    chk("smul_lo", lo, 32'hFFFF_FFEB);
    chk("smul_busy", bcnt, MUL_BUSY);

    // Signed divide -7 / 2
    run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("sdiv_lo", lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", hi, 32'hFFFF_FFFF);
    chk("sdiv_lat", lat, 34);

    // Signed overflow case wraps
    run_op(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_dz", {31'b0, dz}, 32'h0);

    // Divide by zero short path
    run_op(1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, lat, bcnt);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'h0000_1234);
    chk("dz_flag", {31'b0, dz}, 32'h1);
    chk("dz_lat", lat, 2);

    // Divide interrupted by an ignored start and then an asynchronous reset
    @(negedge clk);
    start = 1'b1; mul_c = 1'b0; div_c = 1'b1; s_mdu = 1'b0; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; mul_c = 1'b1; div_c = 1'b0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", {31'b0, busy}, 32'h1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_hi", hi, 32'h0);
    chk("mid_rst_lo", lo, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_done", {31'b0, done}, 32'h0);
    chk("mid_rst_dz", {31'b0, dz}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Unsigned divide after reset
    run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("udiv_lo", lo, 32'd14);
    chk("udiv_hi", hi, 32'd2);
    chk("udiv_lat", lat, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
